// File: rtl/teclado_scanner_if.sv
// Keypad matrix and key-event bundle between teclado_scanner and its consumer.
// The master drives the columns and key outputs; the slave supplies the row lines.
interface teclado_scanner_if #(
    parameter int N_ROWS = 4,
    parameter int N_COLS = 4,
    parameter int CODE_W = 4
);
    localparam int IDX_W = $clog2(N_ROWS * N_COLS);

    logic [N_ROWS-1:0] filas_in;
    logic [N_COLS-1:0] columnas_out;
    logic [CODE_W-1:0] tecla_code;
    logic [IDX_W-1:0]  tecla_idx;
    logic              tecla_valid;
    logic              tecla_rel;
    logic              tecla_held;

    modport master (
        input  filas_in,
        output columnas_out, tecla_code, tecla_idx, tecla_valid, tecla_rel, tecla_held
    );

    modport slave (
        output filas_in,
        input  columnas_out, tecla_code, tecla_idx, tecla_valid, tecla_rel, tecla_held
    );
endinterface

// File: rtl/teclado_scanner.sv
// Keypad matrix scanner: one-cold column drive, per-frame key classification,
// frame-level debounce and a press/release FSM that emits translated key codes.
module teclado_scanner #(
    parameter int N_ROWS   = 4,
    parameter int N_COLS   = 4,
    parameter int CODE_W   = 4,
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 4,
    parameter int MAP_MODE = 0
) (
    input  logic              clk,
    input  logic              rst,
    teclado_scanner_if.master kb
);
    localparam int IDX_W = $clog2(N_ROWS * N_COLS);
    localparam int COL_W = $clog2(N_COLS);
    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam logic [3:0] DEB = 4'(DEBOUNCE);
    localparam logic [3:0] CALC_MAP [16] = '{
        4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD
    };

    if (MAP_MODE == 0 && (N_ROWS != 4 || N_COLS != 4)) begin : g_bad_map
        $error("teclado_scanner: MAP_MODE=0 requires a 4x4 matrix");
    end
    if (CODE_W < IDX_W) begin : g_bad_code_w
        $error("teclado_scanner: CODE_W too small for N_ROWS*N_COLS keys");
    end
    if (N_ROWS < 2 || N_ROWS > 8 || N_COLS < 2 || N_COLS > 8) begin : g_bad_dims
        $error("teclado_scanner: N_ROWS/N_COLS must be in 2..8");
    end
    if (SCAN_DIV < 4 || DEBOUNCE < 1 || DEBOUNCE > 15) begin : g_bad_timing
        $error("teclado_scanner: SCAN_DIV >= 4 and DEBOUNCE in 1..15 required");
    end

    typedef enum logic [1:0] {CLS_NONE, CLS_ONE, CLS_MULTI} cls_e;
    typedef enum logic {ST_IDLE, ST_HELD} state_e;

    function automatic logic [CODE_W-1:0] map_code(input logic [IDX_W-1:0] k);
        logic [3:0] kk;
        kk = 4'(k);
        if (MAP_MODE == 0) map_code = CODE_W'(CALC_MAP[kk]);
        else               map_code = CODE_W'(k);
    endfunction

    logic [N_ROWS-1:0] s1_q, s1_d, s2_q, s2_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [1:0]        acc_n_q, acc_n_d;
    logic [IDX_W-1:0]  acc_idx_q, acc_idx_d;
    cls_e              prev_cls_q, prev_cls_d;
    logic [IDX_W-1:0]  prev_idx_q, prev_idx_d;
    logic [3:0]        stab_q, stab_d;
    state_e            state_q, state_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              valid_q, valid_d;
    logic              rel_q, rel_d;

    logic              slot_end, frame_end, same, stable;
    logic [1:0]        col_cnt, tot_n;
    logic [2:0]        sum_n;
    logic [IDX_W-1:0]  col_idx, tot_idx;
    cls_e              cls;

    always_comb begin
        s1_d       = kb.filas_in;
        s2_d       = s1_q;
        div_d      = div_q;
        col_d      = col_q;
        acc_n_d    = acc_n_q;
        acc_idx_d  = acc_idx_q;
        prev_cls_d = prev_cls_q;
        prev_idx_d = prev_idx_q;
        stab_d     = stab_q;
        state_d    = state_q;
        code_d     = code_q;
        idx_d      = idx_q;
        valid_d    = 1'b0;
        rel_d      = 1'b0;

        slot_end  = (div_q == DIV_W'(SCAN_DIV - 1));
        frame_end = slot_end && (col_q == COL_W'(N_COLS - 1));

        // Low rows in the column currently driven, saturating at two.
        col_cnt = '0;
        col_idx = '0;
        for (int unsigned r = 0; r < N_ROWS; r++) begin
            if (!s2_q[r]) begin
                if (col_cnt != 2'd2) col_cnt = col_cnt + 2'd1;
                col_idx = IDX_W'(r * N_COLS) + IDX_W'(col_q);
            end
        end
        sum_n   = {1'b0, acc_n_q} + {1'b0, col_cnt};
        tot_n   = (sum_n >= 3'd2) ? 2'd2 : sum_n[1:0];
        tot_idx = (col_cnt != 2'd0) ? col_idx : acc_idx_q;

        cls = (tot_n == 2'd0) ? CLS_NONE : (tot_n == 2'd1) ? CLS_ONE : CLS_MULTI;
        same   = (cls == prev_cls_q) && (cls != CLS_ONE || tot_idx == prev_idx_q);
        stable = 1'b0;

        if (!slot_end) begin
            div_d = div_q + DIV_W'(1);
        end else begin
            div_d     = '0;
            col_d     = frame_end ? '0 : col_q + COL_W'(1);
            acc_n_d   = tot_n;
            acc_idx_d = tot_idx;
            if (frame_end) begin
                acc_n_d    = '0;
                acc_idx_d  = '0;
                prev_cls_d = cls;
                prev_idx_d = tot_idx;
                stab_d     = same ? ((stab_q == DEB) ? stab_q : stab_q + 4'd1) : 4'd1;
                stable     = (stab_d == DEB);
                // Any key change while held is ignored until a stable empty frame.
                case (state_q)
                    ST_IDLE: if (stable && cls == CLS_ONE) begin
                        state_d = ST_HELD;
                        idx_d   = tot_idx;
                        code_d  = map_code(tot_idx);
                        valid_d = 1'b1;
                    end
                    ST_HELD: if (stable && cls == CLS_NONE) begin
                        state_d = ST_IDLE;
                        rel_d   = 1'b1;
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q       <= '1;
            s2_q       <= '1;
            div_q      <= '0;
            col_q      <= '0;
            acc_n_q    <= '0;
            acc_idx_q  <= '0;
            prev_cls_q <= CLS_NONE;
            prev_idx_q <= '0;
            stab_q     <= '0;
            state_q    <= ST_IDLE;
            code_q     <= '0;
            idx_q      <= '0;
            valid_q    <= 1'b0;
            rel_q      <= 1'b0;
        end else begin
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            div_q      <= div_d;
            col_q      <= col_d;
            acc_n_q    <= acc_n_d;
            acc_idx_q  <= acc_idx_d;
            prev_cls_q <= prev_cls_d;
            prev_idx_q <= prev_idx_d;
            stab_q     <= stab_d;
            state_q    <= state_d;
            code_q     <= code_d;
            idx_q      <= idx_d;
            valid_q    <= valid_d;
            rel_q      <= rel_d;
        end
    end

    assign kb.columnas_out = ~(N_COLS'(1) << col_q);
    assign kb.tecla_code   = code_q;
    assign kb.tecla_idx    = idx_q;
    assign kb.tecla_valid  = valid_q;
    assign kb.tecla_rel    = rel_q;
    assign kb.tecla_held   = (state_q == ST_HELD);
endmodule
